// File: rtl/taylor_sweep_driver.sv
// Walks a Q1.23 angle sweep through the cosine core; one (angle, cos) result per core latency + 3 cycles, res_ready stalls without limit.
// Optional WAIT watchdog with sticky timeout flag: define TAYLOR_SWEEP_TIMEOUT_EN.
module taylor_sweep_driver #(
  parameter int unsigned    W           = 24,
  parameter logic [W-1:0]   START_ANGLE = W'(838860),
  parameter logic [W-1:0]   STEP        = W'(838860),
  parameter logic [W-1:0]   LIMIT       = W'(13170115),
  parameter int unsigned    TMO_CYCLES  = 4096
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  output logic         busy,
  output logic         done,
  output logic         start,
  output logic [W-1:0] angle_in,
  input  logic         ready_out,
  input  logic [W-1:0] cos_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_angle,
  output logic [W-1:0] res_cos,
  output logic [15:0]  count,
  output logic         timeout
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, NEXT, FIN} state_t;

  state_t       state;
  logic         rdy_q;
  logic         ready_rise;
  logic [W:0]   next_sum;
  logic         next_stop;

  // rdy_q resets high so a core already asserting ready is never seen as a fresh edge
  assign ready_rise = ready_out & ~rdy_q;
  assign next_sum   = {1'b0, angle_in} + {1'b0, STEP};
  assign next_stop  = next_sum[W] || (next_sum[W-1:0] > LIMIT);

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
  localparam int unsigned TW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  assign tmo_hit = (tmo_cnt == TW'(TMO_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYCLES;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      rdy_q     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      start     <= 1'b0;
      angle_in  <= '0;
      res_valid <= 1'b0;
      res_angle <= '0;
      res_cos   <= '0;
      count     <= '0;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
      timeout   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      rdy_q <= ready_out;
      done  <= 1'b0;
      start <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            angle_in <= START_ANGLE;
            count    <= '0;
            busy     <= 1'b1;
            start    <= 1'b1;
            state    <= ISSUE;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end
        WAIT: begin
          if (ready_rise) begin
            res_cos   <= cos_out;
            res_angle <= angle_in;
            res_valid <= 1'b1;
            state     <= HOLD;
          end
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
          else if (tmo_hit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
`endif
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            count     <= count + 16'd1;
            state     <= NEXT;
          end
        end
        NEXT: begin
          // carry out of the W+1 bit sum means the next angle would wrap
          if (next_stop) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            angle_in <= next_sum[W-1:0];
            start    <= 1'b1;
            state    <= ISSUE;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_taylor_sweep_driver.sv
// Bench for taylor_sweep_driver: behavioural cosine-core models, a list-based sweep model and randomized
// latency/backpressure, checked with immediate assertions.
module tb_taylor_sweep_driver;

  localparam int W = 24;
  localparam logic [W-1:0] START = 24'd838860;
  localparam logic [W-1:0] STEP  = 24'd838860;
  localparam logic [W-1:0] LIMIT = 24'd13170115;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic         reset, run, res_ready;
  logic         busy, done, start, res_valid, timeout;
  logic [W-1:0] angle_in, res_angle, res_cos, cos_out;
  logic [15:0]  count;
  logic         ready_out;

  logic         run_e;
  logic [1:0]   e_busy, e_done, e_start, e_res_valid, e_timeout;
  logic [W-1:0] e_angle_in [2];
  logic [W-1:0] e_res_angle [2];
  logic [W-1:0] e_res_cos [2];
  logic [15:0]  e_count [2];

  logic [W-1:0] salt = 24'h5A5A5A;
  function automatic logic [W-1:0] cos_f(input logic [W-1:0] a);
    return (a * 24'd3) ^ salt;
  endfunction

  // Cosine core models: ready drops on start, rises after a random latency with the result.
  int           lat_min = 10, lat_max = 10;
  logic [2:0]   core_start;
  logic [W-1:0] core_ang_in [3];
  logic [W-1:0] core_cap_ang [3];
  logic [W-1:0] auto_cos [3];
  logic [2:0]   auto_rdy = 3'b111;
  int           core_cnt [3];
  logic         core_mode = 1'b1;
  logic         man_ready = 1'b1;
  logic [W-1:0] man_cos = '0;

  assign core_start     = {e_start[1], e_start[0], start};
  assign core_ang_in[0] = angle_in;
  assign core_ang_in[1] = e_angle_in[0];
  assign core_ang_in[2] = e_angle_in[1];
  assign ready_out      = core_mode ? man_ready : auto_rdy[0];
  assign cos_out        = core_mode ? man_cos : auto_cos[0];

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (core_cnt[i] > 0) begin
        core_cnt[i]--;
        if (core_cnt[i] == 0) begin
          auto_rdy[i] = 1'b1;
          auto_cos[i] = cos_f(core_cap_ang[i]);
        end
      end
      if (core_start[i]) begin
        auto_rdy[i]     = 1'b0;
        core_cnt[i]     = $urandom_range(lat_max, lat_min);
        core_cap_ang[i] = core_ang_in[i];
      end
    end
  end

  taylor_sweep_driver dut (
    .clock(clock), .reset(reset), .run(run), .busy(busy), .done(done), .start(start),
    .angle_in(angle_in), .ready_out(ready_out), .cos_out(cos_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_angle(res_angle), .res_cos(res_cos), .count(count), .timeout(timeout)
  );

  taylor_sweep_driver #(.START_ANGLE(24'd13170115)) dut_e1 (
    .clock(clock), .reset(reset), .run(run_e), .busy(e_busy[0]), .done(e_done[0]), .start(e_start[0]),
    .angle_in(e_angle_in[0]), .ready_out(auto_rdy[1]), .cos_out(auto_cos[1]), .res_valid(e_res_valid[0]),
    .res_ready(1'b1), .res_angle(e_res_angle[0]), .res_cos(e_res_cos[0]), .count(e_count[0]),
    .timeout(e_timeout[0])
  );

  taylor_sweep_driver #(.START_ANGLE(24'hFFFFFF), .STEP(24'h800000)) dut_e2 (
    .clock(clock), .reset(reset), .run(run_e), .busy(e_busy[1]), .done(e_done[1]), .start(e_start[1]),
    .angle_in(e_angle_in[1]), .ready_out(auto_rdy[2]), .cos_out(auto_cos[2]), .res_valid(e_res_valid[1]),
    .res_ready(1'b1), .res_angle(e_res_angle[1]), .res_cos(e_res_cos[1]), .count(e_count[1]),
    .timeout(e_timeout[1])
  );

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
  logic         run_t, t_busy, t_done, t_res_valid, t_timeout, t_unused_start;
  logic [W-1:0] t_unused_angle, t_unused_res_angle, t_unused_res_cos;
  logic [15:0]  t_count;
  taylor_sweep_driver #(.TMO_CYCLES(16)) dut_t (
    .clock(clock), .reset(reset), .run(run_t), .busy(t_busy), .done(t_done), .start(t_unused_start),
    .angle_in(t_unused_angle), .ready_out(1'b0), .cos_out('0), .res_valid(t_res_valid),
    .res_ready(1'b1), .res_angle(t_unused_res_angle), .res_cos(t_unused_res_cos), .count(t_count),
    .timeout(t_timeout)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference sweep: every angle START + k*STEP that stays below 2^W and within LIMIT (first is unconditional).
  logic [W-1:0] exp_q [$];
  task automatic build_exp(input longint st, input longint stp, input longint lim);
    longint a;
    a = st;
    exp_q.delete();
    while (1) begin
      exp_q.push_back(a[W-1:0]);
      a = a + stp;
      if (a >= (longint'(1) << W) || a > lim) break;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_angle_in"}, angle_in, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_angle"}, res_angle, 0);
    check({tag, "_res_cos"}, res_cos, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic pulse_run();
    @(negedge clock) run = 1'b1;
    @(negedge clock) run = 1'b0;
    check("run_start", start, 1);
    check("run_busy", busy, 1);
    check("run_angle", angle_in, START);
    check("run_count", count, 0);
  endtask

  // Consume the main sweep with random res_ready (ready_pct percent), optional initial stall.
  task automatic drain(input int ready_pct, input int stall_first, input int period,
                       input int exp_count, input int budget);
    int cyc, dones, last_hs, stall_left;
    logic prev_hold, rr;
    logic [W-1:0] pa, pc, ea;
    dones = 0; last_hs = -1; stall_left = stall_first; prev_hold = 1'b0;
    for (cyc = 0; cyc < budget; cyc++) begin
      @(negedge clock);
      if (done) dones++;
      if (dones > 0 && !busy) break;
      if (prev_hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_angle", res_angle, pa);
        check("hold_cos", res_cos, pc);
      end
      if (res_valid) begin
        check("no_start_in_hold", start, 0);
        rr = (stall_left > 0) ? 1'b0 : ($urandom_range(99, 0) < ready_pct);
        if (stall_left > 0) stall_left--;
        res_ready = rr;
        if (rr) begin
          if (exp_q.size() == 0) check("extra_result", 1, 0);
          else begin
            ea = exp_q.pop_front();
            check("res_angle", res_angle, ea);
            check("res_cos", res_cos, cos_f(ea));
          end
          if (period > 0 && last_hs >= 0) check("result_period", cyc - last_hs, period);
          last_hs = cyc;
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          pa = res_angle;
          pc = res_cos;
        end
      end else begin
        res_ready = ($urandom_range(99, 0) < ready_pct);
        prev_hold = 1'b0;
      end
    end
    res_ready = 1'b0;
    check("sweep_ended", busy, 0);
    check("done_pulses", dones, 1);
    check("sweep_count", count, exp_count);
    check("missing_results", exp_q.size(), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int v, st;
    int e_hs [2];
    int e_dn [2];
    int e_st [2];
    int e_n [2];
    logic [W-1:0] e_exp [2];
`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    int td, tv;
    run_t = 1'b0;
`endif
    reset = 1'b0; run = 1'b0; res_ready = 1'b0; run_e = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    reset = 1'b1;

    // ready_out stuck high from reset: no capture until a genuine low-to-high transition
    salt = 24'($urandom);
    pulse_run();
    v = 0;
    repeat (30) begin
      @(negedge clock);
      v += res_valid;
    end
    check("stuck_no_capture", v, 0);
    check("stuck_busy", busy, 1);
    man_ready = 1'b0;
    @(negedge clock);
    man_cos = cos_f(START);
    man_ready = 1'b1;
    repeat (4) @(negedge clock);
    check("edge_capture_valid", res_valid, 1);
    check("edge_capture_angle", res_angle, START);
    check("edge_capture_cos", res_cos, cos_f(START));
    core_mode = 1'b0;
    build_exp(START, STEP, LIMIT);
    drain(100, 0, 0, 15, 600);

    // default sweep, fixed latency 10, res_ready high: latency + 3 per result
    salt = 24'($urandom);
    build_exp(START, STEP, LIMIT);
    pulse_run();
    drain(100, 0, 13, 15, 600);

    // random latency, a 20-cycle stall on the first result, then random backpressure
    lat_min = 1; lat_max = 15;
    salt = 24'($urandom);
    build_exp(START, STEP, LIMIT);
    pulse_run();
    drain(50, 20, 0, 15, 3000);

    // reset during the third sample's WAIT; the late core result must be ignored
    lat_min = 10; lat_max = 10;
    pulse_run();
    res_ready = 1'b1;
    st = 1;
    for (int c = 0; c < 200 && st < 3; c++) begin
      @(negedge clock);
      if (start) st++;
    end
    check("reached_sample3", st, 3);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_reset_vals("mid_wait_rst");
    v = 0;
    repeat (20) begin
      @(negedge clock);
      v += res_valid + busy;
    end
    check("late_result_ignored", v, 0);
    res_ready = 1'b0;

    // another random sweep after the reset
    lat_min = 1; lat_max = 8;
    salt = 24'($urandom);
    build_exp(START, STEP, LIMIT);
    pulse_run();
    drain(30, 0, 0, 15, 3000);

    // edge parameters: start at LIMIT, and start at 2^24-1 where the next step carries out
    lat_min = 4; lat_max = 4;
    build_exp(24'd13170115, STEP, LIMIT);
    e_exp[0] = exp_q[0]; e_n[0] = exp_q.size();
    build_exp(24'hFFFFFF, 24'h800000, LIMIT);
    e_exp[1] = exp_q[0]; e_n[1] = exp_q.size();
    for (int i = 0; i < 2; i++) begin
      e_hs[i] = 0; e_dn[i] = 0; e_st[i] = 0;
    end
    @(negedge clock) run_e = 1'b1;
    @(negedge clock) run_e = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if (e_start[i]) e_st[i]++;
        if (e_done[i]) e_dn[i]++;
        if (e_res_valid[i]) begin
          e_hs[i]++;
          check("edge_res_angle", e_res_angle[i], e_exp[i]);
          check("edge_res_cos", e_res_cos[i], cos_f(e_exp[i]));
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      check("edge_results", e_hs[i], e_n[i]);
      check("edge_starts", e_st[i], e_n[i]);
      check("edge_done", e_dn[i], 1);
      check("edge_count", e_count[i], e_n[i]);
      check("edge_busy", e_busy[i], 0);
      check("edge_timeout", e_timeout[i], 0);
    end

`ifdef TAYLOR_SWEEP_TIMEOUT_EN
    // core that never answers: watchdog ends the sweep within 19 cycles of run
    td = 0; tv = 0;
    @(negedge clock) run_t = 1'b1;
    @(negedge clock) run_t = 1'b0;
    for (int c = 2; c <= 19; c++) begin
      @(negedge clock);
      td += t_done;
      tv += t_res_valid;
    end
    check("tmo_flag", t_timeout, 1);
    check("tmo_done", td, 1);
    check("tmo_no_result", tv, 0);
    check("tmo_count", t_count, 0);
    check("tmo_busy", t_busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
